// File: rtl/cpu_dispatch_pkg.sv
// Shared definitions for the operand dispatcher and the ALU units it feeds.
// Opcode encodings double as channel indices.
package cpu_dispatch_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } opcode_e;

endpackage

// File: rtl/dispatch_slot.sv
// One per-channel holding slot: full bit, operand registers and a wrapping dispatch counter.
// A load in the same cycle as a drain wins, so a channel can sustain one transfer per cycle.
module dispatch_slot #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    output logic              full_o,
    output logic [DATA_W-1:0] rs1_o,
    output logic [DATA_W-1:0] rs2_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] rs1_q, rs1_d;
    logic [DATA_W-1:0] rs2_q, rs2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        full_d = full_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        cnt_d  = cnt_q;
        if (drain_i && full_q) begin
            full_d = 1'b0;
        end
        if (load_i) begin
            full_d = 1'b1;
            rs1_d  = rs1_i;
            rs2_d  = rs2_i;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign full_o = full_q;
    assign rs1_o  = rs1_q;
    assign rs2_o  = rs2_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/operand_dispatch.sv
// Routes an rs1/rs2 operand pair to one of NUM_CH execution-unit slots selected by opcode.
// Opcodes beyond NUM_CH are swallowed and flagged with a one-cycle error pulse.
module operand_dispatch
    import cpu_dispatch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_opcode,
    input  logic [DATA_W-1:0]        in_rs1,
    input  logic [DATA_W-1:0]        in_rs2,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_rs1,
    output logic [NUM_CH*DATA_W-1:0] out_rs2,
    output logic                     err_opcode,
    output logic [NUM_CH*CNT_W-1:0]  disp_cnt
);

    logic [NUM_CH-1:0] sel_onehot;
    logic [NUM_CH-1:0] load;
    logic              legal;
    logic              err_q, err_d;

    // One-hot decode keeps out-of-range opcodes from ever indexing past the slot array.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_onehot[i] = (in_opcode == SEL_W'(i));
        end
        legal    = |sel_onehot;
        in_ready = legal ? |(sel_onehot & (~out_valid | out_ready)) : 1'b1;
        load     = {NUM_CH{in_valid && in_ready}} & sel_onehot;
        err_d    = in_valid && !legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_opcode = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        dispatch_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[g]),
            .drain_i (out_ready[g]),
            .rs1_i   (in_rs1),
            .rs2_i   (in_rs2),
            .full_o  (out_valid[g]),
            .rs1_o   (out_rs1[g*DATA_W +: DATA_W]),
            .rs2_o   (out_rs2[g*DATA_W +: DATA_W]),
            .cnt_o   (disp_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_operand_dispatch.sv
// Scoreboard bench: a 4-channel dispatcher for routing/backpressure/reset, and a
// 3-channel, 2-bit-counter instance for illegal opcodes and counter wrap.
module tb_operand_dispatch;
    import cpu_dispatch_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        aInValid;
    logic        aInReady;
    logic [1:0]  aInOpcode;
    logic [15:0] aInRs1;
    logic [15:0] aInRs2;
    logic [3:0]  aOutValid;
    logic [3:0]  aOutReady;
    logic [63:0] aOutRs1;
    logic [63:0] aOutRs2;
    logic        aErr;
    logic [31:0] aDispCnt;

    logic        bInValid;
    logic        bInReady;
    logic [1:0]  bInOpcode;
    logic [15:0] bInRs1;
    logic [15:0] bInRs2;
    logic [2:0]  bOutValid;
    logic [2:0]  bOutReady;
    logic [47:0] bOutRs1;
    logic [47:0] bOutRs2;
    logic        bErr;
    logic [5:0]  bDispCnt;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] expQ [4][$];

    operand_dispatch u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (aInValid),
        .in_ready   (aInReady),
        .in_opcode  (aInOpcode),
        .in_rs1     (aInRs1),
        .in_rs2     (aInRs2),
        .out_valid  (aOutValid),
        .out_ready  (aOutReady),
        .out_rs1    (aOutRs1),
        .out_rs2    (aOutRs2),
        .err_opcode (aErr),
        .disp_cnt   (aDispCnt)
    );

    operand_dispatch #(
        .NUM_CH (3),
        .CNT_W  (2)
    ) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (bInValid),
        .in_ready   (bInReady),
        .in_opcode  (bInOpcode),
        .in_rs1     (bInRs1),
        .in_rs2     (bInRs2),
        .out_valid  (bOutValid),
        .out_ready  (bOutReady),
        .out_rs1    (bOutRs1),
        .out_rs2    (bOutRs2),
        .err_opcode (bErr),
        .disp_cnt   (bDispCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Presents one operand pair at posedge+1, checks in_ready mid-cycle and queues the expectation.
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] rs1, input logic [15:0] rs2,
                                 input logic expReady);
        aInValid  = 1'b1;
        aInOpcode = op;
        aInRs1    = rs1;
        aInRs2    = rs2;
        @(negedge clk);
        checkOutput($sformatf("in_ready op%0d", op), 64'(aInReady), 64'(expReady));
        if (expReady) expQ[op].push_back({rs1, rs2});
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        aInValid = 1'b0;
        bInValid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every drain on the 4-channel instance must match the oldest queued pair for that channel.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (aOutValid[i] && aOutReady[i]) begin
                    if (expQ[i].size() == 0) begin
                        checkOutput($sformatf("ch%0d unexpected drain", i), 64'd1, 64'd0);
                    end else begin
                        checkOutput($sformatf("ch%0d drain data", i),
                                    64'({aOutRs1[i*16 +: 16], aOutRs2[i*16 +: 16]}),
                                    64'(expQ[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        aInValid  = 1'b0;
        aInOpcode = '0;
        aInRs1    = '0;
        aInRs2    = '0;
        aOutReady = '0;
        bInValid  = 1'b0;
        bInOpcode = '0;
        bInRs1    = '0;
        bInRs2    = '0;
        bOutReady = '0;

        #3;
        checkOutput("reset out_valid", 64'(aOutValid), 64'd0);
        checkOutput("reset out_rs1", 64'(aOutRs1), 64'd0);
        checkOutput("reset disp_cnt", 64'(aDispCnt), 64'd0);
        checkOutput("reset err_opcode", 64'(aErr), 64'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op to the MUL channel.
        applyStimulus(OP_MUL, 16'h1234, 16'h00FF, 1'b1);
        aInValid = 1'b0;
        @(negedge clk);
        checkOutput("single out_valid", 64'(aOutValid), 64'b0100);
        checkOutput("single ch2 rs1", 64'(aOutRs1[32 +: 16]), 64'h1234);
        checkOutput("single ch2 rs2", 64'(aOutRs2[32 +: 16]), 64'h00FF);
        checkOutput("single disp_cnt", 64'(aDispCnt), 64'h0001_0000);
        @(posedge clk);
        #1;

        // Backpressure on channel 1 must not block channel 3.
        applyStimulus(OP_SUB, 16'hAAAA, 16'hBBBB, 1'b1);
        applyStimulus(OP_SUB, 16'hDEAD, 16'hBEEF, 1'b0);
        applyStimulus(OP_DIV, 16'h3333, 16'h4444, 1'b1);
        aInValid = 1'b0;
        @(negedge clk);
        checkOutput("bp out_valid", 64'(aOutValid), 64'b1110);
        checkOutput("bp ch1 rs1 held", 64'(aOutRs1[16 +: 16]), 64'hAAAA);
        checkOutput("bp disp_cnt", 64'(aDispCnt), 64'h0101_0100);
        @(posedge clk);
        #1;
        aOutReady = 4'hF;
        idleCycles(2);
        @(negedge clk);
        checkOutput("drained out_valid", 64'(aOutValid), 64'd0);
        checkOutput("data held after drain", 64'(aOutRs1[48 +: 16]), 64'h3333);
        @(posedge clk);
        #1;

        // Back-to-back loads into channel 0 with its consumer always ready.
        aOutReady = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(OP_ADD, 16'(16'h0010 + k), 16'(k), 1'b1);
        end
        aInValid = 1'b0;
        idleCycles(1);
        @(negedge clk);
        checkOutput("b2b out_valid", 64'(aOutValid), 64'd0);
        checkOutput("b2b disp_cnt", 64'(aDispCnt), 64'h0101_0105);
        @(posedge clk);
        #1;

        // Fill every slot, then reset asynchronously between edges.
        aOutReady = 4'h0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'(k), 16'(16'h5000 + k), 16'(16'h6000 + k), 1'b1);
        end
        aInValid = 1'b0;
        @(negedge clk);
        checkOutput("all full out_valid", 64'(aOutValid), 64'hF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 64'(aOutValid), 64'd0);
        checkOutput("async reset out_rs1", 64'(aOutRs1), 64'd0);
        checkOutput("async reset out_rs2", 64'(aOutRs2), 64'd0);
        checkOutput("async reset disp_cnt", 64'(aDispCnt), 64'd0);
        for (int i = 0; i < 4; i++) expQ[i].delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First edge after reset release already accepts.
        applyStimulus(OP_DIV, 16'h7777, 16'h8888, 1'b1);
        aInValid = 1'b0;
        @(negedge clk);
        checkOutput("post reset out_valid", 64'(aOutValid), 64'b1000);
        @(posedge clk);
        #1;
        aOutReady = 4'hF;
        idleCycles(2);

        // Illegal opcode on the 3-channel instance.
        bInValid  = 1'b1;
        bInOpcode = 2'd3;
        bInRs1    = 16'h9999;
        bInRs2    = 16'h9999;
        @(negedge clk);
        checkOutput("illegal in_ready", 64'(bInReady), 64'd1);
        checkOutput("illegal err before", 64'(bErr), 64'd0);
        @(posedge clk);
        #1;
        bInValid = 1'b0;
        @(negedge clk);
        checkOutput("illegal err pulse", 64'(bErr), 64'd1);
        checkOutput("illegal out_valid", 64'(bOutValid), 64'd0);
        checkOutput("illegal disp_cnt", 64'(bDispCnt), 64'd0);
        @(negedge clk);
        checkOutput("illegal err cleared", 64'(bErr), 64'd0);
        @(posedge clk);
        #1;

        // Five accepts into a 2-bit counter wrap it to 1.
        bOutReady = 3'b111;
        for (int k = 1; k <= 5; k++) begin
            bInValid  = 1'b1;
            bInOpcode = 2'd2;
            bInRs1    = 16'(k);
            bInRs2    = 16'(16'h0100 + k);
            @(negedge clk);
            checkOutput($sformatf("wrap in_ready %0d", k), 64'(bInReady), 64'd1);
            @(posedge clk);
            #1;
        end
        bInValid = 1'b0;
        @(negedge clk);
        checkOutput("wrap disp_cnt", 64'(bDispCnt), 64'b01_00_00);
        checkOutput("wrap ch2 rs2", 64'(bOutRs2[32 +: 16]), 64'h0105);
        checkOutput("wrap err", 64'(bErr), 64'd0);
        @(posedge clk);
        #1;
        idleCycles(2);

        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ch%0d queue empty", i), 64'(expQ[i].size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/operand_dispatch.md
# operand_dispatch

Parametrised operand dispatcher that routes a source-operand pair (rs1, rs2) from register read to one of NUM_CH execution units, selected by opcode. Successor to the combinational per-operand 1x4 demux. Adds registered per-channel holding slots, valid/ready handshakes on both sides, an illegal-opcode error pulse and per-channel dispatch counters. Sits between register-file read and the ADD/SUB/MUL/DIV units.

## Interface
Parameters:
- DATA_W, 16, operand width
- NUM_CH, 4, number of execution channels (2..16, need not be power of 2)
- SEL_W, $clog2(NUM_CH), opcode/select width (derived, do not override)
- CNT_W, 8, width of each per-channel dispatch counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  dispatcher accepts this cycle
- in_opcode  in  SEL_W  target channel
- in_rs1  in  DATA_W  source operand 1
- in_rs2  in  DATA_W  source operand 2
- out_valid  out  NUM_CH  per-channel slot holds data
- out_ready  in  NUM_CH  per-channel unit consumes this cycle
- out_rs1  out  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
- out_rs2  out  NUM_CH*DATA_W  same packing
- err_opcode  out  1  one-cycle pulse: illegal opcode accepted
- disp_cnt  out  NUM_CH*CNT_W  per-channel accepted-transfer count, channel i at [i*CNT_W +: CNT_W]

## Operation
- Each channel owns one slot: full bit plus rs1/rs2 registers.
- Accept = in_valid && in_ready.
- in_ready:
  - Legal opcode: !full[op] || out_ready[op].
  - Opcode >= NUM_CH: in_ready = 1.
- Accept with legal opcode op: slot[op] loads rs1/rs2, full[op] set, disp_cnt[op] increments. Counters wrap mod 2^CNT_W, no saturation.
- Accept with illegal opcode: data discarded, no slot or counter changes, err_opcode = 1 next cycle.
- Drain: out_valid[i] && out_ready[i] clears full[i], unless the same cycle also loads channel i.
- Simultaneous drain and load on one channel: slot takes new data, full stays 1. Gives full throughput of one transfer/cycle per channel.
- Slots are independent. A stalled channel never blocks traffic to other channels except through in_ready when that channel is addressed (head-of-line blocking at input is accepted behaviour).
- out_rs1/out_rs2 hold their last value when the slot is empty (no zeroing). Only out_valid qualifies them.
- Once out_valid[i] is high, slot data is stable until drained.
- out_ready[i] while empty: ignored.

## Timing
- Latency: accept in cycle N -> out_valid[op] high in cycle N+1.
- in_ready is combinational from in_opcode, full and out_ready. No combinational path from in_valid to in_ready.
- err_opcode is registered, high exactly one cycle after an illegal accept.
- Reset (async assert, sync-safe deassert is the integrator's job) clears:
  - all full bits, so out_valid = 0
  - out_rs1 = 0, out_rs2 = 0
  - err_opcode = 0
  - disp_cnt = 0
- Reset mid-transfer drops held data silently.
- First accept is possible in the first clock edge after rst_n deasserts.

## Structure
- Package cpu_dispatch_pkg holds:
  - opcode enum OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3
  - default DATA_W and NUM_CH localparams shared with the ALU units
- Sub-module dispatch_slot, instantiated NUM_CH times via generate. It contains the full bit, data registers, load/drain logic and counter.
- Top level contains only opcode decode, in_ready mux and err_opcode register.

## Test plan
- Reset then single op: opcode=2, rs1=0x1234, rs2=0x00FF, out_ready=0 -> cycle+1 out_valid=4'b0100, channel 2 data 0x1234/0x00FF, disp_cnt[2]=1, others 0.
- Backpressure: channel 1 full, out_ready[1]=0, opcode=1 -> in_ready=0. Then opcode=3 -> in_ready=1, channel 3 loads, channel 1 unchanged.
- Back-to-back same channel: out_ready[0]=1 held, 5 consecutive opcode=0 transfers with rs2=1..5 -> in_ready stays 1, channel 0 shows 1..5 on consecutive cycles, disp_cnt[0]=5.
- Illegal opcode: NUM_CH=3, opcode=3 -> in_ready=1, err_opcode pulses one cycle, no out_valid change, counters unchanged.
- Counter wrap: CNT_W=2, 5 accepts to channel 2 -> disp_cnt[2]=1.
- Reset mid-operation: all four slots full, assert rst_n=0 between edges -> out_valid=0, data=0, counters=0 immediately, without waiting for a clock edge.
